// File: rtl/bch_pkg.sv
// bch_pkg: shared code constants, state encoding and counter width for the shortened cyclic code
package bch_pkg;
  localparam int BCH_N = 41;
  localparam int BCH_K = 31;
  localparam int BCH_P = 10;
  localparam logic [BCH_P:0] BCH_GEN_POLY = 11'h409;
  localparam int BCH_CW = $clog2(BCH_N);
  typedef enum logic [1:0] {IDLE, SYND, SEARCH, DONE} bch_state_e;
endpackage

// File: rtl/bch_gf_mulx.sv
// bch_gf_mulx: one step of (s*x + in_bit) mod g(x)
module bch_gf_mulx
  import bch_pkg::*;
(
  input  logic [BCH_P-1:0] s,
  input  logic             in_bit,
  output logic [BCH_P-1:0] s_next
);
  logic [BCH_P:0] t;
  assign t = {s, in_bit};
  assign s_next = t[BCH_P] ? t[BCH_P-1:0] ^ BCH_GEN_POLY[BCH_P-1:0] : t[BCH_P-1:0];
endmodule

// File: rtl/dec_top.sv
// dec_top: serial syndrome decoder with single-bit error search and correction
module dec_top
  import bch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BCH_N-1:0] in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCH_K-1:0] out_data,
  output logic             out_corrected,
  output logic             out_uncorr,
  output logic [5:0]       out_err_pos
);
  bch_state_e        state_q, state_d;
  logic [BCH_N-1:0]  cw_q, cw_d;
  logic [BCH_P-1:0]  s_q, s_d, p_q, p_d, mulx_in, mulx_out;
  logic [BCH_CW-1:0] cnt_q, cnt_d;
  logic              corr_q, corr_d, uncorr_q, uncorr_d, mulx_bit;
  logic [5:0]        pos_q, pos_d;
  // the multiplier is time-shared: syndrome division in SYND, x^i stepping in SEARCH
  assign mulx_in  = (state_q == SEARCH) ? p_q : s_q;
  assign mulx_bit = (state_q == SYND) && cw_q[cnt_q];
  bch_gf_mulx u_mulx (.s(mulx_in), .in_bit(mulx_bit), .s_next(mulx_out));
  always_comb begin
    state_d  = state_q;
    cw_d     = cw_q;
    s_d      = s_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    pos_d    = pos_q;
    case (state_q)
      IDLE: if (in_valid) begin
        cw_d     = in_cw;
        s_d      = '0;
        cnt_d    = BCH_CW'(BCH_N - 1);
        corr_d   = 1'b0;
        uncorr_d = 1'b0;
        pos_d    = '0;
        state_d  = SYND;
      end
      SYND: begin
        s_d   = mulx_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          p_d     = BCH_P'(1);
          state_d = (mulx_out == '0) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        if (p_q == s_q) begin
          cw_d[cnt_q] = ~cw_q[cnt_q];
          corr_d      = 1'b1;
          pos_d       = 6'(cnt_q);
          state_d     = DONE;
        end else if (cnt_q == BCH_CW'(BCH_N - 1)) begin
          uncorr_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          p_d   = mulx_out;
        end
      end
      DONE: if (out_ready) begin
        corr_d   = 1'b0;
        uncorr_d = 1'b0;
        pos_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cw_q     <= '0;
      s_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      cw_q     <= cw_d;
      s_q      <= s_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      pos_q    <= pos_d;
    end
  end
  assign in_ready      = (state_q == IDLE) && !rst;
  assign out_valid     = (state_q == DONE);
  assign out_data      = cw_q[BCH_N-1:BCH_P];
  assign out_corrected = corr_q;
  assign out_uncorr    = uncorr_q;
  assign out_err_pos   = pos_q;
endmodule

// File: tb/tb_dec_top.sv
// tb_dec_top: scoreboard bench for dec_top against a polynomial-division reference model
module tb_dec_top;
  import bch_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [40:0] in_cw = '0;
  logic        in_ready, out_valid, out_corrected, out_uncorr;
  logic [30:0] out_data;
  logic [5:0]  out_err_pos;

  dec_top dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corrected(out_corrected), .out_uncorr(out_uncorr), .out_err_pos(out_err_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] data;
    logic        corr;
    logic        uncorr;
    logic [5:0]  pos;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, checks = 0, fails = 0, rdy_mode = 0;
  logic seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // long division of r(x) by g(x)
  function automatic logic [9:0] pmod(input logic [40:0] r);
    logic [40:0] t = r;
    for (int j = 40; j >= 10; j--)
      if (t[j]) t ^= 41'(BCH_GEN_POLY) << (j - 10);
    return t[9:0];
  endfunction

  function automatic logic [40:0] encode(input logic [30:0] d);
    logic [40:0] c = {d, 10'b0};
    c[9:0] = pmod(c);
    return c;
  endfunction

  function automatic exp_t model(input logic [40:0] r);
    exp_t        e;
    logic [9:0]  s = pmod(r);
    logic [40:0] f;
    e.data = r[40:10]; e.corr = 1'b0; e.uncorr = 1'b0; e.pos = '0; e.lat = 41; e.acc = 0;
    if (s != 0) begin
      e.uncorr = 1'b1; e.lat = 82;
      for (int j = 0; j < 41; j++)
        if (e.uncorr && pmod(41'b1 << j) == s) begin
          f = r ^ (41'b1 << j);
          e.uncorr = 1'b0; e.corr = 1'b1; e.pos = 6'(j); e.lat = 42 + j; e.data = f[40:10];
        end
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_output: got out_valid=1 expected no output pending");
        end else chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
      end
      if (out_ready) begin
        if (q.size() != 0) begin
          chk("out_data", 64'(out_data), 64'(q[0].data));
          chk("out_corrected", 64'(out_corrected), 64'(q[0].corr));
          chk("out_uncorr", 64'(out_uncorr), 64'(q[0].uncorr));
          chk("out_err_pos", 64'(out_err_pos), 64'(q[0].pos));
          void'(q.pop_front());
        end
        seen = 1'b0;
      end
    end
  end

  // caller must be at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [40:0] r);
    exp_t e = model(r);
    int   n = 0;
    in_cw = r;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [40:0] r;
    logic [31:0] rv;
    logic [30:0] sd, sc;
    logic        sk, su;
    logic [5:0]  sp;
    int          n;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_corrected", 64'(out_corrected), 64'(0));
    chk("rst_uncorr", 64'(out_uncorr), 64'(0));
    chk("rst_err_pos", 64'(out_err_pos), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    send(encode(31'd5));
    drain();
    send(encode(31'd9) ^ 41'd1);
    drain();
    for (int j = 40; j >= 0; j--) begin
      send(encode(31'h7FFFFFFF) ^ (41'b1 << j));
      drain();
    end
    send(encode(31'd3) ^ (41'b1 << 2) ^ (41'b1 << 17));
    drain();

    rdy_mode = 2;
    send(encode(31'h1234567) ^ (41'b1 << 12));
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'(1));
    sd = out_data; sk = out_corrected; su = out_uncorr; sp = out_err_pos;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'(out_data), 64'(sd));
      chk("hold_flags", 64'({out_corrected, out_uncorr, out_err_pos}), 64'({sk, su, sp}));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    rdy_mode = 0;
    @(negedge clk);
    chk("done_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    sc = 31'h55AA55A;
    send(encode(sc) ^ (41'b1 << 33));
    drain();

    send(encode(31'h2AAAAAAA) ^ (41'b1 << 30));
    repeat (50) @(negedge clk);
    chk("search_no_valid", 64'(out_valid), 64'(0));
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", 64'(in_ready), 64'(1));
    chk("after_rst_flags", 64'({out_valid, out_corrected, out_uncorr}), 64'(0));
    send(encode(31'd1));
    drain();

    rdy_mode = 1;
    for (int w = 0; w < 60; w++) begin
      rv = $urandom;
      r = encode(rv[30:0]);
      n = $urandom_range(0, 2);
      for (int e = 0; e < n; e++) r ^= 41'b1 << $urandom_range(0, 40);
      send(r);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before 5ms");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dec_top.md
Name: dec_top

Overview:
Sequential decoder for the systematic shortened cyclic code produced by enc_top: 41-bit codeword in, 31-bit data out.
- Phase 1 computes the syndrome S = r(x) mod g(x) serially.
- Phase 2 searches bit positions 0..40 for a single-bit error and corrects it; a nonzero syndrome with no match is flagged uncorrectable.
- Sits at the receive end of the link, after storage/channel, opposite enc_top; valid/ready on both sides.

Parameters:
N, 41, codeword length
K, 31, data length
P, 10, parity length (N-K), degree of g(x)
GEN_POLY, 11'h409, g(x)=x^10+x^3+1; must equal the polynomial enc_top uses

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  codeword offered
in_ready  out  1  decoder idle, accepts codeword
in_cw  in  41  received word; bit j = coeff of x^j; [40:10] data, [9:0] parity
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_data  out  31  corrected data (cw[40:10])
out_corrected  out  1  one bit was flipped
out_uncorr  out  1  nonzero syndrome, no single-bit match
out_err_pos  out  6  flipped bit index (0..40); 0 when not corrected

Behaviour:
- Reset: state=IDLE. out_valid=0, out_data=0, flags=0, out_err_pos=0. in_ready=0 while rst is high, 1 in the first cycle after. rst mid-operation discards the in-flight word; no output is produced for it.
- Handshakes: in_ready = (state==IDLE). Transfer occurs on in_valid&in_ready at the edge. Output transfer on out_valid&out_ready. Outputs stay stable while out_valid=1 and out_ready=0.
- IDLE: on accept, latch cw<=in_cw, s<=0, cnt<=40 -> SYND.
- SYND (41 cycles, MSB first): t = {s,cw[cnt]}; s <= t[10] ? t[9:0]^GEN_POLY[9:0] : t[9:0]; cnt--. After processing cnt==0:
  - if the new s==0 -> DONE (no error);
  - else i<=0, p<=10'h001 -> SEARCH.
- SEARCH, one position per cycle:
  - if p==s: cw[i] flipped, out_corrected=1, out_err_pos=i -> DONE;
  - elif i==40: out_uncorr=1 -> DONE;
  - else i++, p <= p*x mod g (same shift/reduce as SYND with input bit 0).
- DONE: out_valid=1. On out_ready -> IDLE and clear flags. in_ready is 0 in DONE, so there is no overlap between output and the next input.
- Latency from the accepting edge to out_valid high:
  - clean word: 41 cycles;
  - error at position i: 42+i cycles;
  - uncorrectable: 82 cycles.
- Flags are mutually exclusive.
- Double errors may miscorrect: the code guarantees single-error correction only, and this is accepted behaviour.
- x^i mod g is distinct for all i<41 because g is primitive (order 1023), so single-error correction is unambiguous.
- out_err_pos width is 6 bits; index 40 fits.

Decomposition:
- Package bch_pkg holds:
  - BCH_N, BCH_K, BCH_P, BCH_GEN_POLY (shared with enc_top);
  - state enum {IDLE, SYND, SEARCH, DONE};
  - position-counter width.
- Sub-module bch_gf_mulx: combinational (s, in_bit) -> (s<<1 ^ in_bit) mod g. It is instantiated once and shared between SYND and SEARCH via a mux, since those states never overlap.

Test Plan:
1. Reset, then enc_top codeword for IN=31'd5, no errors -> out_valid exactly 41 cycles after accept; out_data=31'd5, corrected=0, uncorr=0.
2. Codeword for IN=31'd9 with bit 0 flipped -> out_valid at cycle 42; out_data=31'd9, corrected=1, err_pos=0.
3. Codeword for IN=31'h7FFFFFFF with bit 40 flipped -> out_valid at cycle 82; out_data=31'h7FFFFFFF, err_pos=40. Repeat, sweeping each single-bit position 0..40; all must correct.
4. Codeword for IN=31'd3 with bits 2 and 17 flipped -> either uncorr=1 at cycle 82, or corrected=1 with the position matching the software model; no hang.
5. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then pulse out_ready: in_ready=1 next cycle, and a back-to-back in_valid is accepted.
6. Assert rst during SEARCH -> next cycle out_valid=0 and in_ready=1 after rst drops. A following clean word for IN=31'd1 decodes to 31'd1 with no stale flags.
